// File: rtl/seq_divider_if.sv
// Operand, request and result signals shared by the divider and whoever drives it.
interface seq_divider_if;
  logic       start;
  logic [4:0] x;
  logic [4:0] y;
  logic [4:0] q;
  logic [4:0] r;
  logic       divzero;
  logic       busy;
  logic       done;

  modport master (output start, x, y, input q, r, divzero, busy, done);
  modport slave  (input start, x, y, output q, r, divzero, busy, done);
endinterface

// File: rtl/seq_divider.sv
// 5-bit unsigned restoring divider, one quotient bit per clock, with a
// divide-by-zero shortcut and a one-cycle done pulse.
module seq_divider (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic [4:0] quo_reg, quo_next;
  logic [4:0] rem_reg, rem_next;
  logic [4:0] div_reg, div_next;
  logic [4:0] q_reg, q_next;
  logic [4:0] r_reg, r_next;
  logic       dz_reg, dz_next;

  logic [5:0] p;
  logic       ge;
  logic [4:0] step_quo;
  logic [4:0] step_rem;

  // The 6-bit compare keeps the bit shifted out of the remainder's MSB; when
  // it wins, P - Y < Y fits in 5 bits, so a 5-bit subtract is exact.
  always_comb begin
    p        = {rem_reg, quo_reg[4]};
    ge       = (p >= {1'b0, div_reg});
    step_quo = {quo_reg[3:0], ge};
    step_rem = ge ? (p[4:0] - div_reg) : p[4:0];
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    quo_next   = quo_reg;
    rem_next   = rem_reg;
    div_next   = div_reg;
    q_next     = q_reg;
    r_next     = r_reg;
    dz_next    = dz_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          div_next = bus.y;
          if (bus.y == 5'd0) begin
            state_next = DONE;
            q_next     = 5'b11111;
            r_next     = bus.x;
            dz_next    = 1'b1;
          end else begin
            state_next = DIV;
            cnt_next   = 3'd0;
            quo_next   = bus.x;
            rem_next   = 5'd0;
          end
        end
      end
      DIV: begin
        quo_next = step_quo;
        rem_next = step_rem;
        cnt_next = cnt_reg + 3'd1;
        if (cnt_reg == 3'd4) begin
          state_next = DONE;
          q_next     = step_quo;
          r_next     = step_rem;
          dz_next    = 1'b0;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
      quo_reg   <= 5'd0;
      rem_reg   <= 5'd0;
      div_reg   <= 5'd0;
      q_reg     <= 5'd0;
      r_reg     <= 5'd0;
      dz_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      quo_reg   <= quo_next;
      rem_reg   <= rem_next;
      div_reg   <= div_next;
      q_reg     <= q_next;
      r_reg     <= r_next;
      dz_reg    <= dz_next;
    end
  end

  assign bus.q       = q_reg;
  assign bus.r       = r_reg;
  assign bus.divzero = dz_reg;
  assign bus.busy    = (state_reg != IDLE);
  assign bus.done    = (state_reg == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic/timeline model checked every
// cycle, plus directed cases with hand-computed results and a full sweep.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_divider_if bus ();

  seq_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Model: absolute edge numbers of accept / done and the pending result.
  int         edge_n    = 0;
  int         acc_edge  = 1 << 30;
  int         done_edge = -1;
  int         free_edge = 0;
  int         mx = 0, my = 0;
  logic [4:0] pq = 5'd0, pr = 5'd0;
  logic       pdz = 1'b0;
  logic [4:0] mq = 5'd0, mr = 5'd0;
  logic       mdz = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act != exp)
      $display("FAIL %s: got %0d, expected %0d (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
    else
      pass_cnt++;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      acc_edge  = 1 << 30;
      done_edge = -1;
      free_edge = 0;
      mq  = 5'd0;
      mr  = 5'd0;
      mdz = 1'b0;
    end else begin
      edge_n++;
      if (edge_n >= free_edge && bus.start) begin
        mx = int'(bus.x);
        my = int'(bus.y);
        acc_edge = edge_n;
        if (my == 0) begin
          pq = 5'd31; pr = bus.x; pdz = 1'b1;
          done_edge = edge_n;
        end else begin
          pq = 5'(mx / my); pr = 5'(mx % my); pdz = 1'b0;
          done_edge = edge_n + 5;
        end
        // DONE returns to IDLE without sampling start, so the next accept is two edges on.
        free_edge = done_edge + 2;
      end
      if (edge_n == done_edge) begin
        mq = pq; mr = pr; mdz = pdz;
      end
    end
  end

  initial forever begin
    int e_busy, e_done;
    @(negedge clk);
    e_busy = (edge_n >= acc_edge && edge_n <= done_edge) ? 1 : 0;
    e_done = (edge_n == done_edge) ? 1 : 0;
    chk("cyc_busy", int'(bus.busy), e_busy);
    chk("cyc_done", int'(bus.done), e_done);
    chk("cyc_q", int'(bus.q), int'(mq));
    chk("cyc_r", int'(bus.r), int'(mr));
    chk("cyc_divzero", int'(bus.divzero), int'(mdz));
    if (bus.done)
      $display("txn x=%0d y=%0d -> q=%0d r=%0d divzero=%0d at edge %0d",
               mx, my, bus.q, bus.r, bus.divzero, edge_n);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected end", $time);
    $fatal(1);
  end

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run(input logic [4:0] a, input logic [4:0] b,
                     input int eq, input int er, input int edz, input int elat);
    int n;
    @(negedge clk);
    bus.x = a; bus.y = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_accept", int'(bus.busy), 1);
    wait_done(n);
    chk("latency", n, elat);
    chk("res_q", int'(bus.q), eq);
    chk("res_r", int'(bus.r), er);
    chk("res_divzero", int'(bus.divzero), edz);
    @(negedge clk);
    chk("done_low_after", int'(bus.done), 0);
    chk("busy_low_after", int'(bus.busy), 0);
  endtask

  initial begin
    int n, prev_done;
    logic [4:0] cx, cy;
    bus.start = 1'b0; bus.x = 5'd0; bus.y = 5'd0;
    repeat (3) @(negedge clk);
    chk("reset_q", int'(bus.q), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    rst = 1'b0;

    run(5'd23, 5'd4, 5, 3, 0, 5);
    run(5'd31, 5'd1, 31, 0, 0, 5);
    run(5'd7, 5'd9, 0, 7, 0, 5);
    run(5'd31, 5'd31, 1, 0, 0, 5);
    run(5'd13, 5'd0, 31, 13, 1, 0);

    // A second request raised mid-operation is neither executed nor queued.
    @(negedge clk);
    bus.x = 5'd23; bus.y = 5'd4; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.x = 5'd9; bus.y = 5'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.x = 5'd17; bus.y = 5'd2;
    wait_done(n);
    bus.start = 1'b0;
    chk("ignore_q", int'(bus.q), 5);
    chk("ignore_r", int'(bus.r), 3);
    repeat (2) @(negedge clk);
    chk("ignore_not_run", int'(bus.busy), 0);

    // Asynchronous reset between edges 2 and 3 of a divide.
    @(negedge clk);
    bus.x = 5'd23; bus.y = 5'd4; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_q", int'(bus.q), 0);
    chk("async_r", int'(bus.r), 0);
    chk("async_divzero", int'(bus.divzero), 0);
    chk("async_busy", int'(bus.busy), 0);
    chk("async_done", int'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    run(5'd20, 5'd6, 3, 2, 0, 5);

    // Exhaustive sweep with start held high.
    prev_done = -1;
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      cx = 5'(i >> 5);
      cy = 5'(i);
      bus.x = cx; bus.y = cy;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.done && n < 20);
      chk("sweep_done_seen", int'(bus.done), 1);
      if (cy != 5'd0) begin
        chk("sweep_identity", int'(bus.q) * int'(cy) + int'(bus.r), int'(cx));
        chk("sweep_r_lt_y", (bus.r < cy) ? 1 : 0, 1);
        chk("sweep_divzero", int'(bus.divzero), 0);
        if (prev_done >= 0) chk("sweep_gap", edge_n - prev_done, 7);
      end else begin
        chk("sweep_dz_flag", int'(bus.divzero), 1);
        chk("sweep_dz_q", int'(bus.q), 31);
        chk("sweep_dz_r", int'(bus.r), int'(cx));
      end
      prev_done = edge_n;
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
